// File: rtl/fpmul_pkg.sv
// Shared definitions for the FP multiplier result stage: float field widths,
// special-value constructors, flag bit positions and the occupancy state encoding.
package fpmul_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int FLOAT_W = SIGN_W + EXP_W + MANT_W;

  localparam logic [FLOAT_W-2:0] INF_MAG  = {{EXP_W{1'b1}}, {MANT_W{1'b0}}};
  localparam logic [FLOAT_W-2:0] ZERO_MAG = '0;

  localparam int FLAG_UDF = 0;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_W   = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  function automatic logic [FLOAT_W-1:0] signed_inf(input logic sign);
    return {sign, INF_MAG};
  endfunction

  function automatic logic [FLOAT_W-1:0] signed_zero(input logic sign);
    return {sign, ZERO_MAG};
  endfunction

endpackage

// File: rtl/fpmul_result_stage_if.sv
// Handshake bundle between the multiplier, the result stage and its consumer.
// The stage itself uses the slave modport; the environment uses master.
interface fpmul_result_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_underflow;
  logic        in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_flags;

  modport slave (
    input  in_valid, in_result, in_underflow, in_overflow, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

  modport master (
    output in_valid, in_result, in_underflow, in_overflow, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

endinterface

// File: rtl/fpmul_result_fifo.sv
// Result buffer: storage, wrapping pointers, entry count and EMPTY/PARTIAL/FULL
// occupancy machine. Head data reads as zero whenever the buffer is empty.
module fpmul_result_fifo
  import fpmul_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_req,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop_req,
  output logic                     can_push,
  output logic                     has_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  occ_state_t state, state_next;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic push, pop;

  // Handshake readiness depends only on registered state, never on pop_req
  assign can_push = (state != OCC_FULL);
  assign has_data = (state != OCC_EMPTY);
  assign push     = push_req && can_push;
  assign pop      = pop_req && has_data;
  assign rd_data  = has_data ? mem[rd_ptr] : '0;

  always_comb begin
    state_next = state;
    unique case (state)
      OCC_EMPTY:   if (push) state_next = OCC_PARTIAL;
      OCC_PARTIAL: begin
        if (push && !pop && level == LW'(DEPTH - 1))
          state_next = OCC_FULL;
        else if (pop && !push && level == LW'(1))
          state_next = OCC_EMPTY;
      end
      OCC_FULL:    if (pop) state_next = OCC_PARTIAL;
      default:     state_next = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= OCC_EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        level <= level + LW'(1);
      else if (pop && !push)
        level <= level - LW'(1);
    end
  end

  // Storage is deliberately left unreset; rd_data masks it while empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fpmul_result_stage.sv
// FP multiplier result stage: overflow/underflow fix-up ahead of a small result FIFO.
// Define FPMUL_STATUS_CNT_EN to add saturating ovf_cnt/udf_cnt exception counters.
module fpmul_result_stage
  import fpmul_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter bit FTZ   = 1'b1,
  parameter bit SAT   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fpmul_result_stage_if.slave    bus,
  output logic [$clog2(DEPTH):0] level
`ifdef FPMUL_STATUS_CNT_EN
  ,
  output logic [7:0]             ovf_cnt,
  output logic [7:0]             udf_cnt
`endif
);

  logic [FLOAT_W-1:0] fixed;
  logic [FLAG_W-1:0]  flags;
  logic [FLAG_W+FLOAT_W-1:0] head;

  // Overflow takes priority over underflow when both flags arrive together
  always_comb begin
    fixed = bus.in_result;
    if (bus.in_overflow && SAT)
      fixed = signed_inf(bus.in_result[FLOAT_W-1]);
    else if (bus.in_underflow && FTZ)
      fixed = signed_zero(bus.in_result[FLOAT_W-1]);
  end

  always_comb begin
    flags           = '0;
    flags[FLAG_UDF] = bus.in_underflow;
    flags[FLAG_OVF] = bus.in_overflow;
  end

  fpmul_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FLAG_W + FLOAT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_req (bus.in_valid),
    .wr_data  ({flags, fixed}),
    .pop_req  (bus.out_ready),
    .can_push (bus.in_ready),
    .has_data (bus.out_valid),
    .rd_data  (head),
    .level    (level)
  );

  assign bus.out_data  = head[FLOAT_W-1:0];
  assign bus.out_flags = head[FLAG_W+FLOAT_W-1:FLOAT_W];

`ifdef FPMUL_STATUS_CNT_EN
  logic push;
  assign push = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else if (push) begin
      if (bus.in_overflow && ovf_cnt != 8'hFF)  ovf_cnt <= ovf_cnt + 8'd1;
      if (bus.in_underflow && udf_cnt != 8'hFF) udf_cnt <= udf_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpmul_result_stage.sv
// Self-checking bench for fpmul_result_stage (DEPTH=4, FTZ=1, SAT=1) against a
// queue-based reference model; counter checks apply when FPMUL_STATUS_CNT_EN is set.
module tb_fpmul_result_stage;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  flags;
  } entry_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] level;
`ifdef FPMUL_STATUS_CNT_EN
  logic [7:0] ovf_cnt;
  logic [7:0] udf_cnt;
  int         model_ovf;
  int         model_udf;
`endif

  fpmul_result_stage_if bus();

  fpmul_result_stage #(.DEPTH(DEPTH), .FTZ(1'b1), .SAT(1'b1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .level   (level)
`ifdef FPMUL_STATUS_CNT_EN
    ,
    .ovf_cnt (ovf_cnt),
    .udf_cnt (udf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  entry_t q[$];
  int testCount = 0;
  int failCount = 0;

  function automatic logic [31:0] expectFix(logic [31:0] r, logic u, logic o);
    if (o) return {r[31], 8'hFF, 23'h0};
    if (u) return {r[31], 31'h0};
    return r;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(string tag);
    int n;
    n = q.size();
    checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'(n != 0));
    checkOutput({tag, ".in_ready"},  32'(bus.in_ready),  32'(n != DEPTH));
    checkOutput({tag, ".level"},     32'(level),         32'(n));
    checkOutput({tag, ".out_data"},  bus.out_data,       (n != 0) ? q[0].data : 32'h0);
    checkOutput({tag, ".out_flags"}, 32'(bus.out_flags), (n != 0) ? 32'(q[0].flags) : 32'h0);
`ifdef FPMUL_STATUS_CNT_EN
    checkOutput({tag, ".ovf_cnt"},   32'(ovf_cnt),       32'(model_ovf));
    checkOutput({tag, ".udf_cnt"},   32'(udf_cnt),       32'(model_udf));
`endif
  endtask

  task automatic applyStimulus(logic v, logic [31:0] d, logic u, logic o, logic r);
    bus.in_valid     = v;
    bus.in_result    = d;
    bus.in_underflow = u;
    bus.in_overflow  = o;
    bus.out_ready    = r;
  endtask

  // Advance one clock: update the model from pre-edge inputs, then check after the edge
  task automatic stepCycle(string tag);
    bit canPush, canPop;
    entry_t e;
    canPush = q.size() < DEPTH;
    canPop  = q.size() > 0;
    if (bus.out_ready && canPop) void'(q.pop_front());
    if (bus.in_valid && canPush) begin
      e.data  = expectFix(bus.in_result, bus.in_underflow, bus.in_overflow);
      e.flags = {bus.in_overflow, bus.in_underflow};
      q.push_back(e);
`ifdef FPMUL_STATUS_CNT_EN
      if (bus.in_overflow  && model_ovf < 255) model_ovf++;
      if (bus.in_underflow && model_udf < 255) model_udf++;
`endif
    end
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    q.delete();
`ifdef FPMUL_STATUS_CNT_EN
    model_ovf = 0;
    model_udf = 0;
`endif
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkAll("reset_release");
  endtask

  initial begin
    logic [31:0] d;
    int k;
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    doReset();

    // Plain push with consumer ready, then let it drain
    applyStimulus(1'b1, 32'h40400000, 1'b0, 1'b0, 1'b1);
    stepCycle("plain_push");
    checkOutput("plain_data_const", bus.out_data, 32'h40400000);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    stepCycle("plain_drain");

    // Overflow saturation, both signs, and underflow / both-flag cases
    applyStimulus(1'b1, 32'h7A000000, 1'b0, 1'b1, 1'b0);
    stepCycle("ovf_pos");
    checkOutput("ovf_pos_const", bus.out_data, 32'h7F800000);
    checkOutput("ovf_pos_flags", 32'(bus.out_flags), 32'h2);
    applyStimulus(1'b1, 32'hFA000000, 1'b0, 1'b1, 1'b1);
    stepCycle("ovf_neg_pop");
    checkOutput("ovf_neg_const", bus.out_data, 32'hFF800000);
    applyStimulus(1'b1, 32'h80123456, 1'b1, 1'b0, 1'b1);
    stepCycle("udf_neg_pop");
    checkOutput("udf_neg_const", bus.out_data, 32'h80000000);
    checkOutput("udf_neg_flags", 32'(bus.out_flags), 32'h1);
    applyStimulus(1'b1, 32'h00654321, 1'b1, 1'b1, 1'b1);
    stepCycle("both_flags");
    checkOutput("both_const", bus.out_data, 32'h7F800000);
    checkOutput("both_flags_bits", 32'(bus.out_flags), 32'h3);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    stepCycle("flags_drain");

    // Fill past capacity with consumer stalled, then drain in order
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h3F800000 + 32'(i), 1'b0, 1'b0, 1'b0);
      stepCycle("fill");
    end
    checkOutput("full_level", 32'(level), 32'd4);
    checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1);
    stepCycle("full_push_pop");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      stepCycle("drain");
    end
    checkOutput("drained_level", 32'(level), 32'd0);

    // Hold two entries while pushing and popping together, then reset mid-stream
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'h41000000 + 32'(i), 1'b0, 1'b0, 1'b0);
      stepCycle("pre_steady");
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h42000000 + 32'(i), 1'b0, 1'b0, 1'b1);
      stepCycle("steady");
      checkOutput("steady_level", 32'(level), 32'd2);
    end
    applyStimulus(1'b1, 32'h43000000, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midreset_level", 32'(level), 32'd0);
    checkOutput("midreset_out_data", bus.out_data, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    doReset();

    // Randomized traffic with mixed flags and backpressure
    for (int i = 0; i < 300; i++) begin
      d = $urandom;
      k = int'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 3) != 0, d, (k == 1) || (k == 2),
                    (k == 0) || (k == 2), $urandom_range(0, 2) != 0);
      stepCycle("random");
    end

`ifdef FPMUL_STATUS_CNT_EN
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    doReset();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, $urandom, 1'b0, 1'b1, 1'b1);
      stepCycle("ovf_count");
    end
    checkOutput("ovf_cnt_sat", 32'(ovf_cnt), 32'hFF);
    checkOutput("udf_cnt_zero", 32'(udf_cnt), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/fpmul_result_stage.md
FPMUL_RESULT_STAGE -- requirements
Module: fpmul_result_stage

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered results (power of two, 2..16).
REQ-002 Parameter FTZ, default 1, flush underflowed results to signed zero when 1.
REQ-003 Parameter SAT, default 1, replace overflowed results with signed infinity when 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  multiplier result present this cycle.
REQ-007 in_ready  output  1  stage can accept a result.
REQ-008 in_result  input  32  IEEE-754 single product (sign, exp[30:23], mant[22:0]).
REQ-009 in_underflow  input  1  exponent underflow flag from multiplier.
REQ-010 in_overflow  input  1  exponent overflow flag from multiplier.
REQ-011 out_valid  output  1  head entry available.
REQ-012 out_ready  input  1  consumer takes head entry.
REQ-013 out_data  output  32  fixed-up result at head.
REQ-014 out_flags  output  2  head flags: bit0 underflow, bit1 overflow, as received.
REQ-015 level  output  $clog2(DEPTH)+1  current entry count.
REQ-016 ovf_cnt, udf_cnt  output  8 each  exception counters (present only with macro, REQ-032).

Function
REQ-017 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-018 in_ready = (level != DEPTH), derived from registered state only; no combinational path from out_ready.
REQ-019 out_valid = (level != 0); out_data/out_flags driven from registered head storage.
REQ-020 Latency: result pushed at edge N is visible on out_* after edge N; zero-entry bypass not permitted.
REQ-021 Fix-up applied before storage: overflow && SAT -> {sign, 8'hFF, 23'h0}; else underflow && FTZ -> {sign, 31'h0}; else in_result unchanged.
REQ-022 If both flags set, overflow fix-up wins; both flag bits stored.
REQ-023 Occupancy state machine EMPTY, PARTIAL, FULL: EMPTY->PARTIAL on push; PARTIAL->FULL on push without pop reaching DEPTH; FULL->PARTIAL on pop; PARTIAL->EMPTY on pop without push reaching 0.
REQ-024 Simultaneous push and pop in PARTIAL: level unchanged, order preserved.
REQ-025 Simultaneous push and pop in EMPTY: push only (out_valid low). In FULL: pop only (in_ready low).
REQ-026 in_valid while FULL: input ignored, no state change; upstream holds data.
REQ-027 Read/write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-028 out_data/out_flags stable while out_valid && !out_ready.

Reset
REQ-029 rst_n low asynchronously: level=0, state EMPTY, pointers 0, out_valid=0, in_ready=1 after release, out_data=0, out_flags=0, counters 0.
REQ-030 Reset mid-operation discards all buffered entries; no partial pop/push completes.
REQ-031 Storage array contents need not be reset; outputs must read 0 while EMPTY.

Configuration
REQ-032 Macro FPMUL_STATUS_CNT_EN defined: ovf_cnt/udf_cnt ports exist; each increments by 1 per push with corresponding flag set, saturates at 8'hFF, clears only on reset.
REQ-033 Macro undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-034 Shared package fpmul_pkg holds float field widths (1/8/23), the signed-infinity and signed-zero constants, flag bit indices, and the occupancy state encoding.
REQ-035 One sub-module fpmul_result_fifo (storage, pointers, level, state) instantiated once; fix-up and counters reside in the top.

Verification
REQ-036 Push 32'h40400000 (3.0), no flags, out_ready=1 -> out_valid next cycle, out_data 32'h40400000, out_flags 2'b00.
REQ-037 Push 32'h7A000000 with overflow, SAT=1 -> out_data 32'h7F800000, flags 2'b10; sign-set input 32'hFA000000 -> 32'hFF800000.
REQ-038 Push 32'h80123456 with underflow, FTZ=1 -> out_data 32'h80000000, flags 2'b01; both flags set -> infinity, flags 2'b11.
REQ-039 out_ready=0, five pushes, DEPTH=4 -> level 4, in_ready 0, fifth ignored; then drain -> first four in order, level 0.
REQ-040 Level 2, simultaneous push/pop 10 cycles -> level stays 2, pointer wrap, order intact; assert rst_n low mid-stream -> out_valid 0 immediately, level 0.
REQ-041 With FPMUL_STATUS_CNT_EN, 300 overflow pushes -> ovf_cnt 8'hFF, udf_cnt 0.
